seg_display_scan_ctrl: RTL and testbench
========================================

# seg_display_scan_ctrl

Controller that owns the shared `bcd_7_seg` decoder for a 4-digit multiplexed seven-segment display. It accepts a binary value over a valid/ready handshake and converts it to four BCD digits with a sequential double-dabble engine. It commits the digits to display registers, then time-multiplexes them onto the single decoder's `bcd` input while driving active-low digit anodes. It sits between the value producer and the `bcd_7_seg` instance plus the board anode pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected; legal range ≥2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a value on `in_value`.
- `in_ready`  out  1  controller can accept a value (high only in IDLE).
- `in_value`  in  14  unsigned binary value to display; legal display range 0..9999.
- `blank_lz`  in  1  level; when 1, leading-zero digits are blanked.
- `bcd`  out  4  nibble to the shared `bcd_7_seg` decoder.
- `an`  out  4  active-low one-hot digit enable; bit 0 = ones digit, bit 3 = thousands.
- `busy`  out  1  conversion in progress (CONVERT or COMMIT).
- `ovf`  out  1  last committed value exceeded 9999.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: `in_ready`=1, `busy`=0. On `in_valid && in_ready`, latch `in_value` into the shift register, clear the BCD accumulator, load the step counter with 14, and go to CONVERT.
  - CONVERT: one double-dabble step per cycle. Add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. Decrement the step counter and go to COMMIT after the 14th step.
  - COMMIT: write the 4 digits to the display registers and update `ovf`, then go to IDLE.
- Overflow: if the latched value is >9999, the conversion still runs its full length. COMMIT writes 4'hA to all four digits and sets `ovf`=1. The decoder's default arm then shows the DP only. A later in-range commit clears `ovf`.
- `in_value` is sampled only on the handshake edge. Changes during CONVERT are ignored. `in_valid` outside IDLE is ignored; there is no queueing.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of FSM state.
  - On wrap, the digit index advances 0→1→2→3→0.
  - `bcd` = display_reg[index].
  - `an` = active-low one-hot of index.
- Blanking: when `blank_lz`=1 and `ovf`=0, digit k (k≥1) is blanked if it and all higher digits are zero. A blanked digit has `an`=4'b1111 for its slot, and `bcd` is still driven. Digit 0 is never blanked.
- The display registers change only in COMMIT, so the shown value never tears mid-conversion.

## Timing
- Reset values:
  - FSM = IDLE.
  - Display registers, refresh counter, and digit index = 0.
  - `in_ready`=1, `busy`=0, `ovf`=0, `bcd`=4'h0, `an`=4'b1110.
- Handshake accepted at edge T:
  - `in_ready` low and `busy` high from T through T+15.
  - CONVERT steps on edges T+1..T+14.
  - COMMIT writes the display on edge T+15.
  - IDLE resumes after T+15, so `in_ready`=1 in the cycle after edge T+15.
- Maximum throughput is one value per 16 cycles. With `in_valid` held high, accepts occur at T, T+16, T+32, …
- `bcd` and `an` are combinational from registered state. Both change one cycle after a scan-counter wrap or after COMMIT.
- `rst` mid-conversion aborts the conversion and discards the value. All registers take their reset values on that edge, and `in_ready`=1 the next cycle.
- `rst` asserted together with `in_valid`: reset wins and no accept occurs.

## Test plan
- Reset, REFRESH_DIV=4: `an`=1110, `bcd`=0, `in_ready`=1. `an` then rotates 1110→1101→1011→0111 every 4 cycles with `bcd`=0, 0, 0, 0 (`blank_lz`=0).
- Load 1234 at edge T: `in_ready`=0 for T..T+15, display updates at T+15. The scan then shows `bcd`=4,3,2,1 on `an`=1110,1101,1011,0111. Also load 9999 → 9,9,9,9 with `ovf`=0.
- `blank_lz`=1, load 7: only `an`=1110 ever goes low, with `bcd`=7. Load 0: digit 0 still lit with `bcd`=0. Load 105: digits 0–2 lit, showing 5,0,1.
- Load 10000: all digits `bcd`=4'hA and `ovf`=1, and blanking is not applied. Then load 42: `ovf`=0, scan shows 2,4,0,0.
- `in_valid` held high with values 11, 22, 33: accepts at T, T+16, T+32. Values changed mid-conversion are ignored.
- Load 5678, then assert `rst` at T+7: no commit occurs and the display stays 0. `in_ready`=1 the cycle after reset, and a new load of 99 commits 15 cycles after its accept.

Source files
------------

// File: rtl/seg_display_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller: sequential double-dabble
// binary-to-BCD conversion with tear-free commit and anode scanning.
module seg_display_scan_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] in_value,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        busy,
  output logic        ovf
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   acc_q, acc_d;
  logic [3:0]    step_q, step_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          lead_zero_s;

  // Double-dabble pre-shift correction: every BCD nibble >= 5 gets +3.
  function automatic logic [15:0] dabble_adj(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int k = 0; k < 4; k++) begin
      if (a[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = a[k*4 +: 4] + 4'd3;
      else                     r[k*4 +: 4] = a[k*4 +: 4];
    end
    return r;
  endfunction

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    step_d     = step_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d      = in_value;
          acc_d      = 16'h0000;
          step_d     = 4'd14;
          ovf_pend_d = (in_value > 14'd9999);
          state_d    = CONVERT;
        end else begin
          state_d = IDLE;
        end
      end
      CONVERT: begin
        {acc_d, bin_d} = {dabble_adj(acc_q), bin_q} << 1;
        step_d         = step_q - 4'd1;
        if (step_q == 4'd1) state_d = COMMIT;
        else                state_d = CONVERT;
      end
      COMMIT: begin
        // Out-of-range values show 4'hA, which the decoder renders as DP only.
        disp_d  = ovf_pend_q ? 16'hAAAA : acc_q;
        ovf_d   = ovf_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running refresh counter and digit index.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= 14'd0;
      acc_q      <= 16'd0;
      step_q     <= 4'd0;
      ovf_pend_q <= 1'b0;
      disp_q     <= 16'd0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
    end
  end

  // Leading-zero test: the selected digit and everything above it are zero.
  always_comb begin
    case (idx_q)
      2'd1:    lead_zero_s = (disp_q[15:4]  == 12'd0);
      2'd2:    lead_zero_s = (disp_q[15:8]  == 8'd0);
      2'd3:    lead_zero_s = (disp_q[15:12] == 4'd0);
      default: lead_zero_s = 1'b0;
    endcase
  end

  // Decoder nibble and active-low anode drive.
  always_comb begin
    bcd = disp_q[{idx_q, 2'b00} +: 4];
    if (blank_lz && !ovf_q && lead_zero_s) an = 4'b1111;
    else                                   an = ~(4'b0001 << idx_q);
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_seg_display_scan_ctrl.sv
// Bench for seg_display_scan_ctrl: directed scenarios plus random traffic,
// compared every cycle against an arithmetic reference model.
module tb_seg_display_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [13:0] in_value = 14'd0;
  logic        blank_lz = 1'b0;
  logic        in_ready;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cyc;
  int m_busy_cnt;
  int m_pending;
  int m_shown;
  bit m_ovf;
  int p10 [4] = '{1, 10, 100, 1000};

  seg_display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .blank_lz(blank_lz), .bcd(bcd), .an(an),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs presented at that edge.
  task automatic model_edge();
    if (rst) begin
      m_cyc = 0; m_busy_cnt = 0; m_shown = 0; m_ovf = 1'b0;
    end else begin
      m_cyc++;
      if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          m_shown = m_pending;
          m_ovf   = (m_pending > 9999);
        end
      end else if (in_valid) begin
        m_pending  = int'(in_value);
        m_busy_cnt = 15;
      end
    end
  endtask

  task automatic check_outputs();
    int idx;
    int digit;
    logic [3:0] exp_an;
    idx   = (m_cyc / DIV) % 4;
    digit = m_ovf ? 10 : (m_shown / p10[idx]) % 10;
    if (blank_lz && !m_ovf && idx > 0 && m_shown < p10[idx]) exp_an = 4'b1111;
    else                                                    exp_an = 4'hF & ~(4'b0001 << idx);
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, m_busy_cnt == 0});
    check_eq("busy",     {31'd0, busy},     {31'd0, m_busy_cnt != 0});
    check_eq("ovf",      {31'd0, ovf},      {31'd0, m_ovf});
    check_eq("bcd",      {28'd0, bcd},      32'(digit));
    check_eq("an",       {28'd0, an},       {28'd0, exp_an});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic load(input int v, input int wait_cycles);
    in_valid = 1'b1;
    in_value = 14'(v);
    tick();
    in_valid = 1'b0;
    in_value = 14'($urandom_range(0, 16383));
    repeat (wait_cycles) tick();
  endtask

  initial begin
    m_cyc = 0; m_busy_cnt = 0; m_pending = 0; m_shown = 0; m_ovf = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Explicit reset-state checks
    check_eq("rst_an",    {28'd0, an},  {28'd0, 4'b1110});
    check_eq("rst_bcd",   {28'd0, bcd}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (16) tick();

    load(1234, 15);
    check_eq("commit_1234", {28'd0, bcd}, 32'(m_shown / p10[(m_cyc / DIV) % 4] % 10));
    repeat (16) tick();
    load(9999, 31);

    blank_lz = 1'b1;
    load(7, 31);
    load(0, 31);
    load(105, 31);
    load(10000, 31);
    check_eq("ovf_set", {31'd0, ovf}, 32'd1);
    load(42, 31);
    check_eq("ovf_clr", {31'd0, ovf}, 32'd0);
    blank_lz = 1'b0;

    // Held valid: only values present at T, T+16, T+32 may be taken.
    in_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i == 0)       in_value = 14'd11;
      else if (i == 16) in_value = 14'd22;
      else if (i == 32) in_value = 14'd33;
      else              in_value = 14'($urandom_range(0, 16383));
      tick();
    end
    in_valid = 1'b0;
    repeat (20) tick();

    // Reset mid-conversion, then a fresh load.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load(5678, 6);
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) tick();
    load(99, 31);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) in_value = 14'($urandom_range(0, 16383));
      else                           in_value = 14'($urandom_range(0, 150));
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
